// File: rtl/rtype_issue_seq.sv
// Purpose: issues MIPS R-type words to an external combinational ALU and writes results back to a 32x32 RF.
// Latency: accept in cycle N, done in N+2, next accept in N+3.
// Backpressure: instr_ready is low outside IDLE and while a host preload is in flight; the sender holds the word.
module rtype_issue_seq #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [31:0]       alu_in0,
    output logic [31:0]       alu_in1,
    output logic [10:0]       alu_op,
    input  logic [31:0]       alu_out,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_carryout,
    output logic              done,
    output logic [31:0]       res,
    output logic [2:0]        res_flags,
    output logic              illegal,
    output logic              ovf_trap
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t        state, state_nxt;
    logic [31:0]   rf [NREG];

    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd;
    logic [31:0]   rf_rs, rf_rt;
    logic          cls_rr, cls_sh, cls_shv, legal;
    logic [31:0]   dec_in0, dec_in1;
    logic          accept;

    logic [4:0]    wb_rd;
    logic          wb_illegal, wb_trapop;
    logic          ld_we, wb_we;
    logic          unused_shamt;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign unused_shamt = &{1'b0, instr[10:6]};

    assign rf_rs = rf[rs];
    assign rf_rt = rf[rt];

    // Operand routing depends on the funct class; illegal words send zeros.
    always_comb begin
        cls_rr  = 1'b0;
        cls_sh  = 1'b0;
        cls_shv = 1'b0;
        case (funct)
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B:               cls_rr  = 1'b1;
            6'h00, 6'h02, 6'h03:        cls_sh  = 1'b1;
            6'h04, 6'h06, 6'h07:        cls_shv = 1'b1;
            default: ;
        endcase
        legal   = (opcode == 6'd0) && (cls_rr || cls_sh || cls_shv);
        dec_in0 = '0;
        dec_in1 = '0;
        if (legal) begin
            if (cls_rr) begin
                dec_in0 = rf_rs;
                dec_in1 = rf_rt;
            end else if (cls_sh) begin
                dec_in0 = rf_rt;
            end else begin
                dec_in0 = rf_rt;
                dec_in1 = rf_rs;
            end
        end
    end

    assign instr_ready = (state == IDLE) && !ld_en;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done     = (state == WB);
    assign illegal  = done && wb_illegal;
    assign ovf_trap = done && !wb_illegal && wb_trapop && res_flags[2];

    assign ld_we = (state == IDLE) && ld_en && (ld_addr != '0);
    assign wb_we = done && !wb_illegal && (wb_rd != 5'd0) && !(wb_trapop && res_flags[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_in0    <= '0;
            alu_in1    <= '0;
            alu_op     <= '0;
            res        <= '0;
            res_flags  <= '0;
            wb_rd      <= '0;
            wb_illegal <= 1'b0;
            wb_trapop  <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_in0    <= dec_in0;
                alu_in1    <= dec_in1;
                alu_op     <= legal ? {5'b00000, funct} : 11'd0;
                wb_rd      <= rd;
                wb_illegal <= !legal;
                wb_trapop  <= (funct == 6'h20) || (funct == 6'h22);
            end
            // ALU is combinational: its result for the held operands is ready by the end of EXEC.
            if (state == EXEC) begin
                res       <= alu_out;
                res_flags <= {alu_overflow, alu_zero, alu_carryout};
            end
            if (ld_we)
                rf[ld_addr] <= ld_data;
            else if (wb_we)
                rf[wb_rd] <= res;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? 32'd0 : rf[dbg_addr];

endmodule

// File: tb/tb_rtype_issue_seq.sv
module tb_rtype_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic [10:0] alu_op;
    logic        alu_overflow, alu_zero, alu_carryout;
    logic        done, illegal, ovf_trap;
    logic [31:0] res;
    logic [2:0]  res_flags;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        legal;
        logic        illegal;
        logic        trap;
        logic [10:0] op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] res;
        logic [2:0]  flags;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf [32];
    logic [5:0]  legal_f [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    rtype_issue_seq #(.NREG(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .alu_carryout(alu_carryout),
        .done(done), .res(res), .res_flags(res_flags),
        .illegal(illegal), .ovf_trap(ovf_trap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Behavioural 32-bit MIPS ALU: returns {overflow, zero, carryout, out}.
    function automatic logic [34:0] alu_f(input logic [10:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        logic [31:0] o;
        logic        v, c;
        o = '0; v = 1'b0; c = 1'b0; s = '0;
        case (op)
            11'h020, 11'h021: begin
                s = {1'b0, x} + {1'b0, y};
                o = s[31:0]; c = s[32];
                v = (x[31] == y[31]) && (o[31] != x[31]);
            end
            11'h022, 11'h023: begin
                o = x - y; c = (x >= y);
                v = (x[31] != y[31]) && (o[31] != x[31]);
            end
            11'h024: o = x & y;
            11'h025: o = x | y;
            11'h026: o = x ^ y;
            11'h027: o = ~(x | y);
            11'h02A: o = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            11'h02B: o = (x < y) ? 32'd1 : 32'd0;
            11'h000, 11'h004: o = x << y[4:0];
            11'h002, 11'h006: o = x >> y[4:0];
            11'h003, 11'h007: o = $signed(x) >>> y[4:0];
            default: o = '0;
        endcase
        return {v, (o == 32'd0), c, o};
    endfunction

    always_comb {alu_overflow, alu_zero, alu_carryout, alu_out} = alu_f(alu_op, alu_in0, alu_in1);

    function automatic logic [31:0] rw(input int op, input int rs, input int rt, input int rd, input int sh, input int f);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: decode from the instruction word and the model register file.
    task automatic predict(input logic [31:0] w);
        exp_t        e;
        logic [5:0]  f;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b;
        logic [34:0] r;
        f = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
        a = mrf[rs]; b = mrf[rt];
        e.cyc   = cyc;
        e.legal = (w[31:26] == 6'd0) &&
                  (f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
        e.illegal = !e.legal;
        e.op  = e.legal ? {5'd0, f} : 11'd0;
        e.in0 = '0; e.in1 = '0;
        if (f inside {6'h00, 6'h02, 6'h03}) e.in0 = b;
        else if (f inside {6'h04, 6'h06, 6'h07}) begin e.in0 = b; e.in1 = a; end
        else begin e.in0 = a; e.in1 = b; end
        r = alu_f(e.op, e.in0, e.in1);
        e.res   = r[31:0];
        e.flags = r[34:32];
        e.trap  = e.legal && (f == 6'h20 || f == 6'h22) && r[34];
        if (e.legal && !e.trap && rd != 5'd0) mrf[rd] = e.res;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) begin
            chk("issue_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        predict(w);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 5'(a); ld_data = d;
        if (a != 0) mrf[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic rf_is(input string name, input int a, input logic [31:0] v);
        dbg_addr = 5'(a); #1;
        chk(name, dbg_data, v);
    endtask

    task automatic run(input logic [31:0] w);
        issue(w);
        drain();
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    exp_t me;
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                me = sb.pop_front();
                chk("latency", 32'(cyc), 32'(me.cyc + 2));
                chk("illegal", 32'(illegal), 32'(me.illegal));
                chk("ovf_trap", 32'(ovf_trap), 32'(me.trap));
                chk("alu_op", 32'(alu_op), 32'(me.op));
                if (me.legal) begin
                    chk("alu_in0", alu_in0, me.in0);
                    chk("alu_in1", alu_in1, me.in1);
                    chk("res", res, me.res);
                    chk("res_flags", 32'(res_flags), 32'(me.flags));
                end
            end
        end else begin
            chk("flags_idle", 32'({illegal, ovf_trap}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int          n;
        foreach (mrf[i]) mrf[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", alu_in0 | alu_in1 | 32'(alu_op) | res | 32'(res_flags), 32'd0);
        rf_is("rst_rf5", 5, 32'd0);
        rst_n = 1'b1;

        // add r3,r1,r2
        load(1, 32'd7); load(2, 32'd5);
        run(32'h00221820);
        rf_is("add_r3", 3, 32'd12);

        // signed overflow traps, unsigned does not
        load(1, 32'h7FFFFFFF); load(2, 32'd1);
        run(rw(0, 1, 2, 4, 0, 6'h20));
        rf_is("add_ovf_r4", 4, 32'd0);
        run(rw(0, 1, 2, 4, 0, 6'h21));
        rf_is("addu_r4", 4, 32'h80000000);

        load(1, 32'd3); load(2, 32'd3);
        run(rw(0, 1, 2, 5, 0, 6'h23));
        rf_is("subu_r5", 5, 32'd0);
        load(7, 32'hFFFFFFFF);
        run(rw(0, 7, 1, 6, 0, 6'h2A));
        rf_is("slt_r6", 6, 32'd1);

        load(2, 32'd1); load(1, 32'd4);
        run(rw(0, 1, 2, 8, 0, 6'h04));
        rf_is("sllv_r8", 8, 32'd16);
        run(rw(0, 1, 1, 0, 0, 6'h20));
        load(0, 32'd123);
        rf_is("r0_zero", 0, 32'd0);

        // illegal opcode and funct leave RF untouched
        run(rw(8, 1, 2, 9, 0, 6'h20));
        rf_is("illegal_op_r9", 9, 32'd0);
        run(rw(0, 1, 2, 9, 0, 6'h18));
        rf_is("illegal_fn_r9", 9, 32'd0);

        // preload holds off a waiting instruction
        @(negedge clk);
        instr = rw(0, 10, 11, 9, 0, 6'h21); instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld_en = 1'b1; ld_addr = 5'(10 + k); ld_data = 32'(100 + k);
            mrf[10 + k] = 32'(100 + k);
            #1 chk("hold_ready", 32'(instr_ready), 32'd0);
            @(negedge clk);
        end
        ld_en = 1'b0;
        #1 chk("hold_release", 32'(instr_ready), 32'd1);
        predict(instr);
        @(posedge clk); #1 instr_valid = 1'b0;
        drain();
        rf_is("hold_r9", 9, 32'd201);
        rf_is("hold_r12", 12, 32'd102);

        // Randomized traffic against the model
        for (int r = 1; r < 32; r++) begin
            case ($urandom_range(0, 5))
                0:       w = 32'h7FFFFFFF;
                1:       w = 32'h80000000;
                2:       w = 32'hFFFFFFFF;
                3:       w = $urandom_range(0, 40);
                default: w = $urandom;
            endcase
            load(r, w);
        end
        for (int i = 0; i < 250; i++) begin
            w = rw(($urandom_range(0, 9) == 0) ? $urandom_range(1, 63) : 0,
                   $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                               : legal_f[$urandom_range(0, 12)]);
            if ($urandom_range(0, 4) == 0) w[5:0] = 6'(4 + 2 * $urandom_range(0, 1) + $urandom_range(0, 1));
            issue(w);
            n = $urandom_range(0, 9);
            if (n == 0) begin
                drain();
                load($urandom_range(0, 31), $urandom);
            end else if (n < 3) begin
                repeat (n) @(negedge clk);
            end
        end
        drain();
        for (int r = 0; r < 32; r++) rf_is("rand_rf", r, mrf[r]);

        // Reset during EXEC abandons the instruction
        load(1, 32'd9); load(2, 32'd9);
        issue(rw(0, 1, 2, 13, 0, 6'h20));
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        foreach (mrf[i]) mrf[i] = '0;
        #1 chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("rst_mid_outs", alu_in0 | alu_in1 | 32'(alu_op) | res | 32'(res_flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(instr_ready), 32'd1);
        for (int r = 0; r < 32; r++) rf_is("rst_mid_rf", r, 32'd0);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
